ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
// - EX stage of the 5-stage MIPS pipeline: consumes ID_EX outputs, performs operand forwarding,
//   ALU operation and destination select, and registers results into the EX/MEM pipeline register.
// - Sits between ID_EX and the data-memory stage; its registered destination/RegWrite also feed
//   its own forwarding logic and the upstream hazard unit.
// PARAMETERS
// - W        32  datapath width (ALU, operands, results)
// - RW        5  register-index width
// PORTS
// - clock        in   1   rising-edge clock
// - reset_n      in   1   asynchronous, active-low reset
// - ex_mem_write in   1   1=load EX/MEM register, 0=hold (stall)
// - ex_flush     in   1   1=load a bubble (all-zero) next edge
// - WB_MEM       in   4   {RegWrite, MemtoReg, Branch, MemWrite} from ID_EX
// - ALUOp        in   2   00 add, 01 sub, 10 R-type (funct), 11 add
// - MemRead      in   1   load indicator
// - RegDst       in   1   1=Rd, 0=Rt as destination
// - ALUSrc       in   1   1=SignOut as operand B
// - ReadOut1     in   W   rs value
// - ReadOut2     in   W   rt value
// - SignOut      in   W   sign-extended immediate
// - ALUControl   in   6   funct field
// - Rs, Rt, Rd   in   RW  register indices
// - wb_regwrite  in   1   MEM/WB RegWrite
// - wb_reg       in   RW  MEM/WB destination
// - wb_data      in   W   MEM/WB write-back value
// - ex_mem_ctrl  out  4   registered WB_MEM
// - ex_mem_read  out  1   registered MemRead
// - ex_mem_zero  out  1   registered (ALU result == 0)
// - ex_mem_alu   out  W   registered ALU result
// - ex_mem_wdata out  W   registered forwarded operand B (pre-ALUSrc), store data
// - ex_mem_dst   out  RW  registered destination index
// - ex_mem_ovf   out  1   registered signed overflow (optional feature)
// BEHAVIOUR
// - Async reset (reset_n=0): every output register = 0 immediately; held until reset_n rises.
// - Latency: 1 cycle; all outputs registered, no combinational input->output path.
// - Forward A (for Rs), priority order:
//   1) EX/MEM: ex_mem_ctrl[3] & ~ex_mem_read & ex_mem_dst!=0 & ex_mem_dst==Rs -> ex_mem_alu
//   2) MEM/WB: wb_regwrite & wb_reg!=0 & wb_reg==Rs -> wb_data
//   3) otherwise ReadOut1
// - Forward B: identical rules against Rt/ReadOut2; ALUSrc then selects SignOut or forwarded B.
// - Register 0 never forwarded; loads in EX/MEM are not forwarded (hazard unit stalls upstream).
// - ALU, ALUOp=10, by funct:
//   100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed, 1/0);
//   any other funct -> result 0.
// - Arithmetic is modulo 2^W (wrap-around, no saturation); zero flag computed on the W-bit result.
// - Destination: RegDst ? Rd : Rt.
// - Clock edge:
//   ex_flush=1 -> all outputs cleared (flush wins over hold);
//   else ex_mem_write=0 -> all outputs hold;
//   else load the new values.
// - Stall case: during hold, forwarding still uses the held ex_mem_* values.
// CONFIGURATION
// - OVERFLOW_TRAP_EN defined:
//   - signed overflow on add/sub (ALUOp 00/01/11, funct add/sub) sets ex_mem_ovf=1;
//   - the registered RegWrite bit (ex_mem_ctrl[3]) is forced 0 for that instruction;
//   - ALU result is still registered.
// - OVERFLOW_TRAP_EN undefined: ex_mem_ovf constant 0; RegWrite passes unmodified.
// TESTING
// - Reset: assert reset_n=0 mid-cycle with outputs nonzero -> all outputs 0 immediately, before the next edge.
// - R-type and: ReadOut1=0x0000_0020, ReadOut2=0x0000_0027, ALUOp=10, funct=100100, RegDst=1, Rd=16
//   -> ex_mem_alu=0x20, ex_mem_dst=16, ex_mem_zero=0.
// - EX/MEM forwarding: addi $8=0x20 followed by and $16,$8,$9 ($9 via wb_data=0x27)
//   -> A from ex_mem_alu, B from wb_data, result 0x20.
// - Priority/reg-0 cases:
//   - ex_mem_dst=wb_reg=Rs=5 -> EX/MEM value used;
//   - Rs=0 with matching dst=0 -> ReadOut1 used.
// - Stall/flush:
//   - ex_mem_write=0 for 2 cycles -> outputs unchanged;
//   - ex_flush=1 together with ex_mem_write=0 -> outputs 0.
// - Overflow: add 0x7FFF_FFFF+1 -> ex_mem_alu=0x8000_0000;
//   - with OVERFLOW_TRAP_EN: ex_mem_ovf=1, ex_mem_ctrl[3]=0;
//   - without: ex_mem_ovf=0, RegWrite kept.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID_EX -> EX -> EX/MEM bundle for the EX stage, plus the MEM/WB forwarding taps.
// master drives ID_EX/control/write-back inputs; slave is the EX stage itself.
interface ex_stage_if #(
  parameter int W  = 32,
  parameter int RW = 5
);
  logic          ex_mem_write;
  logic          ex_flush;
  logic [3:0]    WB_MEM;
  logic [1:0]    ALUOp;
  logic          MemRead;
  logic          RegDst;
  logic          ALUSrc;
  logic [W-1:0]  ReadOut1;
  logic [W-1:0]  ReadOut2;
  logic [W-1:0]  SignOut;
  logic [5:0]    ALUControl;
  logic [RW-1:0] Rs;
  logic [RW-1:0] Rt;
  logic [RW-1:0] Rd;
  logic          wb_regwrite;
  logic [RW-1:0] wb_reg;
  logic [W-1:0]  wb_data;

  logic [3:0]    ex_mem_ctrl;
  logic          ex_mem_read;
  logic          ex_mem_zero;
  logic [W-1:0]  ex_mem_alu;
  logic [W-1:0]  ex_mem_wdata;
  logic [RW-1:0] ex_mem_dst;
  logic          ex_mem_ovf;

  modport master (
    output ex_mem_write, ex_flush, WB_MEM, ALUOp, MemRead, RegDst, ALUSrc,
           ReadOut1, ReadOut2, SignOut, ALUControl, Rs, Rt, Rd,
           wb_regwrite, wb_reg, wb_data,
    input  ex_mem_ctrl, ex_mem_read, ex_mem_zero, ex_mem_alu, ex_mem_wdata,
           ex_mem_dst, ex_mem_ovf
  );

  modport slave (
    input  ex_mem_write, ex_flush, WB_MEM, ALUOp, MemRead, RegDst, ALUSrc,
           ReadOut1, ReadOut2, SignOut, ALUControl, Rs, Rt, Rd,
           wb_regwrite, wb_reg, wb_data,
    output ex_mem_ctrl, ex_mem_read, ex_mem_zero, ex_mem_alu, ex_mem_wdata,
           ex_mem_dst, ex_mem_ovf
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS EX stage: operand forwarding, ALU, destination select and the EX/MEM register.
// Optional OVERFLOW_TRAP_EN: signed add/sub overflow sets ex_mem_ovf and suppresses RegWrite.
module ex_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic      clock,
  input  logic      reset_n,
  ex_stage_if.slave bus
);
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic [3:0]    ctrl_q,  ctrl_d;
  logic          read_q,  read_d;
  logic          zero_q,  zero_d;
  logic [W-1:0]  alu_q,   alu_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [RW-1:0] dst_q,   dst_d;

  logic          exm_fwd_ok;
  logic [W-1:0]  fwd_a, fwd_b, op_b;
  logic [W-1:0]  sum, diff, alu_res;
  logic          is_add, is_sub, slt_lt;
  logic          ovf;
  logic [3:0]    ctrl_new;

  // Loads sitting in EX/MEM have no data yet; the hazard unit stalls instead.
  assign exm_fwd_ok = ctrl_q[3] & ~read_q & (dst_q != '0);

  always_comb begin
    fwd_a = bus.ReadOut1;
    if (exm_fwd_ok && (dst_q == bus.Rs))
      fwd_a = alu_q;
    else if (bus.wb_regwrite && (bus.wb_reg != '0) && (bus.wb_reg == bus.Rs))
      fwd_a = bus.wb_data;

    fwd_b = bus.ReadOut2;
    if (exm_fwd_ok && (dst_q == bus.Rt))
      fwd_b = alu_q;
    else if (bus.wb_regwrite && (bus.wb_reg != '0) && (bus.wb_reg == bus.Rt))
      fwd_b = bus.wb_data;
  end

  assign op_b   = bus.ALUSrc ? bus.SignOut : fwd_b;
  assign sum    = fwd_a + op_b;
  assign diff   = fwd_a - op_b;
  assign slt_lt = $signed(fwd_a) < $signed(op_b);

  always_comb begin
    is_add  = 1'b0;
    is_sub  = 1'b0;
    alu_res = '0;
    case (bus.ALUOp)
      2'b01: is_sub = 1'b1;
      2'b10: begin
        case (bus.ALUControl)
          F_ADD:   is_add = 1'b1;
          F_SUB:   is_sub = 1'b1;
          F_AND:   alu_res = fwd_a & op_b;
          F_OR:    alu_res = fwd_a | op_b;
          F_NOR:   alu_res = ~(fwd_a | op_b);
          F_SLT:   alu_res = {{(W-1){1'b0}}, slt_lt};
          default: alu_res = '0;
        endcase
      end
      default: is_add = 1'b1;
    endcase
    if (is_add) alu_res = sum;
    if (is_sub) alu_res = diff;
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d;
  // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips sign.
  assign ovf = (is_add & (fwd_a[W-1] == op_b[W-1]) & (sum[W-1]  != fwd_a[W-1])) |
               (is_sub & (fwd_a[W-1] != op_b[W-1]) & (diff[W-1] != fwd_a[W-1]));
`else
  assign ovf = 1'b0;
`endif

  assign ctrl_new = {bus.WB_MEM[3] & ~ovf, bus.WB_MEM[2:0]};

  always_comb begin
    ctrl_d  = ctrl_q;
    read_d  = read_q;
    zero_d  = zero_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    dst_d   = dst_q;
    if (bus.ex_flush) begin
      ctrl_d  = '0;
      read_d  = 1'b0;
      zero_d  = 1'b0;
      alu_d   = '0;
      wdata_d = '0;
      dst_d   = '0;
    end else if (bus.ex_mem_write) begin
      ctrl_d  = ctrl_new;
      read_d  = bus.MemRead;
      zero_d  = (alu_res == '0);
      alu_d   = alu_res;
      wdata_d = fwd_b;
      dst_d   = bus.RegDst ? bus.Rd : bus.Rt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      read_q  <= 1'b0;
      zero_q  <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      dst_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      read_q  <= read_d;
      zero_q  <= zero_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      dst_q   <= dst_d;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ex_flush)
      ovf_d = 1'b0;
    else if (bus.ex_mem_write)
      ovf_d = ovf;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign bus.ex_mem_ovf = ovf_q;
`else
  assign bus.ex_mem_ovf = 1'b0;
`endif

  assign bus.ex_mem_ctrl  = ctrl_q;
  assign bus.ex_mem_read  = read_q;
  assign bus.ex_mem_zero  = zero_q;
  assign bus.ex_mem_alu   = alu_q;
  assign bus.ex_mem_wdata = wdata_q;
  assign bus.ex_mem_dst   = dst_q;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized + directed bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  ex_stage_if #(.W(32), .RW(5)) bus ();

  ex_stage #(.W(32), .RW(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        rd;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic        ovf;
  } exp_t;

  exp_t exp_s;
  exp_t held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctrl"},  {28'd0, bus.ex_mem_ctrl}, {28'd0, exp_s.ctrl});
    chk({tag, ".read"},  {31'd0, bus.ex_mem_read}, {31'd0, exp_s.rd});
    chk({tag, ".zero"},  {31'd0, bus.ex_mem_zero}, {31'd0, exp_s.zero});
    chk({tag, ".alu"},   bus.ex_mem_alu,           exp_s.alu);
    chk({tag, ".wdata"}, bus.ex_mem_wdata,         exp_s.wdata);
    chk({tag, ".dst"},   {27'd0, bus.ex_mem_dst},  {27'd0, exp_s.dst});
    chk({tag, ".ovf"},   {31'd0, bus.ex_mem_ovf},  {31'd0, exp_s.ovf});
  endtask

  // Reference: operand selection by rule, ALU as 64-bit signed arithmetic reduced mod 2^32.
  function automatic exp_t model_next(input exp_t s);
    exp_t n;
    logic [31:0] a, b, opb;
    longint sa, sb, full;
    logic ov;
    n = s;
    if (bus.ex_flush) return '0;
    if (!bus.ex_mem_write) return s;
    a = bus.ReadOut1;
    b = bus.ReadOut2;
    if (s.ctrl[3] && !s.rd && s.dst != 0 && s.dst == bus.Rs) a = s.alu;
    else if (bus.wb_regwrite && bus.wb_reg != 0 && bus.wb_reg == bus.Rs) a = bus.wb_data;
    if (s.ctrl[3] && !s.rd && s.dst != 0 && s.dst == bus.Rt) b = s.alu;
    else if (bus.wb_regwrite && bus.wb_reg != 0 && bus.wb_reg == bus.Rt) b = bus.wb_data;
    opb = bus.ALUSrc ? bus.SignOut : b;
    sa = longint'($signed(a));
    sb = longint'($signed(opb));
    ov = 1'b0;
    full = 0;
    if (bus.ALUOp == 2'b00 || bus.ALUOp == 2'b11 ||
        (bus.ALUOp == 2'b10 && bus.ALUControl == 6'b100000)) begin
      full = sa + sb;
      ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    end else if (bus.ALUOp == 2'b01 ||
                 (bus.ALUOp == 2'b10 && bus.ALUControl == 6'b100010)) begin
      full = sa - sb;
      ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    end else begin
      case (bus.ALUControl)
        6'b100100: full = longint'(a & opb);
        6'b100101: full = longint'(a | opb);
        6'b100111: full = longint'(~(a | opb));
        6'b101010: full = (sa < sb) ? 1 : 0;
        default:   full = 0;
      endcase
    end
    n.alu   = full[31:0];
    n.zero  = (n.alu == 32'd0);
    n.wdata = b;
    n.dst   = bus.RegDst ? bus.Rd : bus.Rt;
    n.rd    = bus.MemRead;
    n.ctrl  = bus.WB_MEM;
`ifdef OVERFLOW_TRAP_EN
    n.ovf = ov;
    if (ov) n.ctrl[3] = 1'b0;
`else
    n.ovf = 1'b0;
`endif
    return n;
  endfunction

  task automatic cycle(input string tag);
    exp_t nxt;
    nxt = model_next(exp_s);
    @(posedge clock);
    exp_s = nxt;
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.ex_mem_write = 1'b1;
    bus.ex_flush     = 1'b0;
    bus.WB_MEM       = 4'b0000;
    bus.ALUOp        = 2'b00;
    bus.MemRead      = 1'b0;
    bus.RegDst       = 1'b0;
    bus.ALUSrc       = 1'b0;
    bus.ReadOut1     = '0;
    bus.ReadOut2     = '0;
    bus.SignOut      = '0;
    bus.ALUControl   = '0;
    bus.Rs           = '0;
    bus.Rt           = '0;
    bus.Rd           = '0;
    bus.wb_regwrite  = 1'b0;
    bus.wb_reg       = '0;
    bus.wb_data      = '0;
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 6))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  logic [5:0] functs [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21, 6'h00};
    exp_s = '0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_all("rst");
    reset_n = 1'b1;

    // R-type and
    bus.ReadOut1 = 32'h20; bus.ReadOut2 = 32'h27; bus.ALUOp = 2'b10;
    bus.ALUControl = 6'b100100; bus.RegDst = 1'b1; bus.Rd = 5'd16;
    bus.Rs = 5'd1; bus.Rt = 5'd2; bus.WB_MEM = 4'b1000;
    cycle("and");
    chk("and_alu",  bus.ex_mem_alu, 32'h20);
    chk("and_dst",  {27'd0, bus.ex_mem_dst}, 32'd16);
    chk("and_zero", {31'd0, bus.ex_mem_zero}, 32'd0);

    // addi $8, $0, 0x20 ; and $16, $8, $9 with $9 from write-back
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.SignOut = 32'h20; bus.Rt = 5'd8; bus.WB_MEM = 4'b1000;
    cycle("addi");
    idle_inputs();
    bus.ALUOp = 2'b10; bus.ALUControl = 6'b100100; bus.Rs = 5'd8; bus.Rt = 5'd9;
    bus.Rd = 5'd16; bus.RegDst = 1'b1; bus.ReadOut1 = 32'h0; bus.ReadOut2 = 32'hFFFF_FFFF;
    bus.wb_regwrite = 1'b1; bus.wb_reg = 5'd9; bus.wb_data = 32'h27; bus.WB_MEM = 4'b1000;
    cycle("fwd");
    chk("fwd_alu",   bus.ex_mem_alu, 32'h20);
    chk("fwd_wdata", bus.ex_mem_wdata, 32'h27);

    // EX/MEM beats MEM/WB for the same register
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.ReadOut1 = 32'h100; bus.SignOut = 32'h11;
    bus.Rt = 5'd5; bus.WB_MEM = 4'b1000;
    cycle("pri0");
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.Rs = 5'd5; bus.ReadOut1 = 32'h3;
    bus.wb_regwrite = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'h999;
    cycle("pri1");
    chk("pri_alu", bus.ex_mem_alu, 32'h111);

    // register 0 is never forwarded
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.SignOut = 32'h55; bus.Rt = 5'd0; bus.WB_MEM = 4'b1000;
    cycle("r0a");
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.Rs = 5'd0; bus.ReadOut1 = 32'h1234;
    bus.wb_regwrite = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'h77;
    cycle("r0b");
    chk("r0_alu", bus.ex_mem_alu, 32'h1234);

    // overflow add
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.ReadOut1 = 32'h7FFF_FFFF; bus.SignOut = 32'h1;
    bus.Rt = 5'd3; bus.WB_MEM = 4'b1000;
    cycle("ovf");
    chk("ovf_alu", bus.ex_mem_alu, 32'h8000_0000);
`ifdef OVERFLOW_TRAP_EN
    chk("ovf_flag", {31'd0, bus.ex_mem_ovf}, 32'd1);
    chk("ovf_rw",   {31'd0, bus.ex_mem_ctrl[3]}, 32'd0);
`else
    chk("ovf_flag", {31'd0, bus.ex_mem_ovf}, 32'd0);
    chk("ovf_rw",   {31'd0, bus.ex_mem_ctrl[3]}, 32'd1);
`endif

    // stall for two cycles with changing inputs
    held = exp_s;
    for (int i = 0; i < 2; i++) begin
      bus.ex_mem_write = 1'b0;
      bus.ReadOut1 = $urandom(); bus.SignOut = $urandom(); bus.Rt = 5'd7;
      cycle("stall");
    end
    chk("stall_alu", bus.ex_mem_alu, held.alu);
    chk("stall_dst", {27'd0, bus.ex_mem_dst}, {27'd0, held.dst});

    // flush wins over hold
    bus.ex_mem_write = 1'b0; bus.ex_flush = 1'b1;
    cycle("flush");
    chk("flush_alu", bus.ex_mem_alu, 32'd0);
    chk("flush_dst", {27'd0, bus.ex_mem_dst}, 32'd0);

    // mid-cycle async reset with nonzero outputs
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.SignOut = 32'hABCD; bus.Rt = 5'd9; bus.WB_MEM = 4'b1111;
    bus.MemRead = 1'b1;
    cycle("prerst");
    #2;
    reset_n = 1'b0;
    #1;
    exp_s = '0;
    check_all("arst");
    @(negedge clock);
    check_all("arst_hold");
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.ex_mem_write = ($urandom_range(0, 4) != 0);
      bus.ex_flush     = ($urandom_range(0, 11) == 0);
      bus.WB_MEM       = 4'($urandom_range(0, 15));
      bus.ALUOp        = 2'($urandom_range(0, 3));
      bus.MemRead      = ($urandom_range(0, 3) == 0);
      bus.RegDst       = 1'($urandom_range(0, 1));
      bus.ALUSrc       = ($urandom_range(0, 2) == 0);
      bus.ReadOut1     = rnd_data();
      bus.ReadOut2     = rnd_data();
      bus.SignOut      = rnd_data();
      bus.ALUControl   = functs[$urandom_range(0, 7)];
      bus.Rs           = 5'($urandom_range(0, 5));
      bus.Rt           = 5'($urandom_range(0, 5));
      bus.Rd           = 5'($urandom_range(0, 5));
      bus.wb_regwrite  = 1'($urandom_range(0, 1));
      bus.wb_reg       = 5'($urandom_range(0, 5));
      bus.wb_data      = rnd_data();
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
